// File: rtl/mul_pkg.sv
// ============================================================================
// Module   : mul_pkg
// Brief    : Op encodings and controller state type for the shared multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        FIXUP = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin grant; the lane not granted last wins a tie.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // Resets as if lane1 went last, so lane0 holds priority first.
    logic r_last;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (update) begin
            r_last <= grant[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_share_ctrl.sv
// ============================================================================
// Module   : mul_share_ctrl
// Brief    : Shares one sequential signed 32x32 multiplier between two lanes,
//            applying RV32M sign fix-up on the returned product.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_share_ctrl
    import mul_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int XLEN    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0][1:0]      req_op,
    input  logic [1:0][XLEN-1:0] req_a,
    input  logic [1:0][XLEN-1:0] req_b,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [XLEN-1:0]      rsp_data,
    output logic                 rsp_err,
    output logic                 mul_en,
    output logic [XLEN-1:0]      mul_a,
    output logic [XLEN-1:0]      mul_b,
    input  logic [2*XLEN-1:0]    mul_p,
    input  logic                 mul_valid
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    logic                r_lane;
    logic [1:0]          r_op;
    logic [2*XLEN-1:0]   r_p;
    logic [c_CNT_W-1:0]  r_cnt;

    logic [1:0]          w_grant;
    logic [1:0]          w_fire;
    logic [1:0]          w_lane_oh;
    logic [XLEN-1:0]     w_ph;
    logic [XLEN-1:0]     w_fix;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .update (|w_fire),
        .grant  (w_grant)
    );

    assign req_ready = (r_state == IDLE) ? w_grant : 2'b00;
    assign w_fire    = req_valid & req_ready;
    assign w_lane_oh = r_lane ? 2'b10 : 2'b01;
    assign w_ph      = r_p[2*XLEN-1:XLEN];

    // The multiplier is signed x signed; unsigned views add back the operand
    // that the sign bit of the other one subtracted from the high word.
    always_comb begin
        w_fix = r_p[XLEN-1:0];
        case (r_op)
            MUL_OP_MUL:    w_fix = r_p[XLEN-1:0];
            MUL_OP_MULH:   w_fix = w_ph;
            MUL_OP_MULHSU: w_fix = w_ph + (mul_b[XLEN-1] ? mul_a : '0);
            MUL_OP_MULHU:  w_fix = w_ph + (mul_a[XLEN-1] ? mul_b : '0)
                                        + (mul_b[XLEN-1] ? mul_a : '0);
            default:       w_fix = r_p[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_lane    <= 1'b0;
            r_op      <= 2'b00;
            r_p       <= '0;
            r_cnt     <= '0;
            mul_en    <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_fire) begin
                        r_lane  <= w_grant[1];
                        r_op    <= req_op[w_grant[1]];
                        mul_a   <= req_a[w_grant[1]];
                        mul_b   <= req_b[w_grant[1]];
                        mul_en  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_en  <= 1'b0;
                    r_cnt   <= c_CNT_W'(1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A product on the final counted cycle still wins over the timeout.
                    if (mul_valid) begin
                        r_p     <= mul_p;
                        r_state <= FIXUP;
                    end else if (r_cnt == c_CNT_W'(TIMEOUT)) begin
                        rsp_valid <= w_lane_oh;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                FIXUP: begin
                    rsp_valid <= w_lane_oh;
                    rsp_data  <= w_fix;
                    rsp_err   <= 1'b0;
                    r_state   <= RESP;
                end
                RESP: begin
                    if (|(rsp_ready & rsp_valid)) begin
                        rsp_valid <= 2'b00;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
// ============================================================================
// Module   : tb_mul_share_ctrl
// Brief    : Directed scoreboard bench for mul_share_ctrl with a behavioural
//            sequential multiplier of programmable latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_share_ctrl;
    import mul_pkg::*;

    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][1:0]  req_op;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic             mul_en;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [63:0]      mul_p;
    logic             mul_valid;

    always #5 clk = ~clk;

    mul_share_ctrl #(.TIMEOUT(TIMEOUT), .XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .mul_valid (mul_valid)
    );

    function automatic logic [63:0] sprod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        return sa * sb;
    endfunction

    // RV32M reference computed from the operand interpretations themselves.
    function automatic logic [31:0] rv_mul(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] ss, su;
        logic [63:0] uu;
        ss = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        su = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
        uu = {32'b0, a} * {32'b0, b};
        case (op)
            2'b00:   return ss[31:0];
            2'b01:   return ss[63:32];
            2'b10:   return su[63:32];
            default: return uu[63:32];
        endcase
    endfunction

    // Behavioural multiplier: product appears lat cycles after the mul_en cycle.
    int          lat = 4;
    logic        stub = 1'b0;
    int          lcnt;
    logic [31:0] ma, mb;
    int          en_count = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mul_en) en_count <= en_count + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid <= 1'b0;
            mul_p     <= 64'h0;
            lcnt      <= 0;
        end else if (mul_en && !stub) begin
            ma        <= mul_a;
            mb        <= mul_b;
            lcnt      <= lat - 1;
            mul_valid <= (lat == 1);
            mul_p     <= (lat == 1) ? sprod(mul_a, mul_b) : 64'hA5A5_5A5A_A5A5_5A5A;
        end else if (lcnt > 0) begin
            lcnt      <= lcnt - 1;
            mul_valid <= (lcnt == 1);
            mul_p     <= (lcnt == 1) ? sprod(ma, mb) : 64'hA5A5_5A5A_A5A5_5A5A;
        end else begin
            mul_valid <= 1'b0;
            mul_p     <= 64'hA5A5_5A5A_A5A5_5A5A;
        end
    end

    typedef struct {
        logic        lane;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;

    logic [1:0]  pv = 2'b00;
    logic [1:0]  p_op  [2];
    logic [31:0] p_a   [2];
    logic [31:0] p_b   [2];
    logic [31:0] p_exp [2];
    logic        p_err [2];
    int          p_lat [2];
    logic        tb_last = 1'b1;
    int          refill_left = 0;
    int          hold_next = 0;
    int          hold_left = 0;
    logic        seen = 1'b0;
    logic [34:0] cur;
    int          last_hs = 0;
    int          last_gap = 0;
    logic        any_rsp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int l, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] e, input logic er,
                           input int lt);
        pv[l]    = 1'b1;
        p_op[l]  = op;
        p_a[l]   = a;
        p_b[l]   = b;
        p_exp[l] = e;
        p_err[l] = er;
        p_lat[l] = lt;
    endtask

    task automatic rand_req(input int l);
        logic [1:0]  op;
        logic [31:0] a, b;
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        b  = $urandom;
        set_req(l, op, a, b, rv_mul(op, a, b), 1'b0, lat + 3);
    endtask

    task automatic step();
        logic [1:0] fired, expv;
        int         l;
        exp_t       e;
        @(negedge clk);
        req_valid = pv;
        for (int i = 0; i < 2; i++) begin
            req_op[i] = p_op[i];
            req_a[i]  = p_a[i];
            req_b[i]  = p_b[i];
        end
        #1;
        fired = req_valid & req_ready;
        if (fired != 2'b00) begin
            expv = (pv == 2'b11) ? (tb_last ? 2'b01 : 2'b10) : pv;
            chk("grant", 64'(fired), 64'(expv));
            l = fired[1] ? 1 : 0;
            tb_last = fired[1];
            q.push_back('{lane: fired[1], data: p_exp[l], err: p_err[l], due: cyc + p_lat[l]});
            last_gap = cyc - last_hs;
            pv[l] = 1'b0;
            if (refill_left > 0) begin
                refill_left--;
                rand_req(l);
            end
        end
        if (rsp_valid != 2'b00) begin
            if (!seen) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'h0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_lane", 64'(rsp_valid), e.lane ? 64'h2 : 64'h1);
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("rsp_latency", 64'(cyc), 64'(e.due));
                end
                cur       = {rsp_valid, rsp_err, rsp_data};
                seen      = 1'b1;
                hold_left = hold_next;
                hold_next = 0;
            end else begin
                chk("rsp_stable", 64'({rsp_valid, rsp_err, rsp_data}), 64'(cur));
            end
            if (hold_left > 0) begin
                hold_left--;
                rsp_ready = ~rsp_valid;
            end else begin
                rsp_ready = rsp_valid;
                seen      = 1'b0;
                last_hs   = cyc;
            end
        end else begin
            rsp_ready = 2'b00;
        end
    endtask

    task automatic run(input int max_cycles);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cycles) begin
            step();
            n++;
            done = (pv == 2'b00) && (q.size() == 0) && !seen && (rsp_valid == 2'b00)
                   && (refill_left == 0);
        end
        chk("drain", 64'(done), 64'h1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
        chk({tag, "_rsp_data"},  64'(rsp_data),  64'h0);
        chk({tag, "_rsp_err"},   64'(rsp_err),   64'h0);
        chk({tag, "_mul_en"},    64'(mul_en),    64'h0);
        chk({tag, "_mul_ab"},    {mul_a, mul_b}, 64'h0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, n;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            p_op[i] = 2'b00; p_a[i] = 32'h0; p_b[i] = 32'h0;
            p_exp[i] = 32'h0; p_err[i] = 1'b0; p_lat[i] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic lane0 MUL with a negative operand; latency is multiplier + 3.
        lat = 4;
        set_req(0, MUL_OP_MUL, 32'd15, 32'hFFFF_FFFC, 32'hFFFF_FFC4, 1'b0, 7);
        run(100);

        set_req(1, MUL_OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 7);
        run(100);
        set_req(0, MUL_OP_MULH, 32'h7FFF_FFFF, 32'd2, 32'h0000_0000, 1'b0, 7);
        run(100);

        // Both lanes at once: lane1 wins (lane0 went last), lane0 fires right after.
        set_req(1, MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 7);
        set_req(0, MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 7);
        run(100);
        chk("back_to_back_gap", 64'(last_gap), 64'h1);

        // Six ops with both lanes always valid; first response held off 3 cycles.
        lat = 3;
        e0 = en_count;
        rand_req(0);
        rand_req(1);
        refill_left = 4;
        hold_next   = 3;
        run(400);
        chk("mul_en_per_op", 64'(en_count - e0), 64'd6);

        // Product on the last counted cycle succeeds; one cycle later times out.
        lat = TIMEOUT;
        set_req(0, MUL_OP_MULHU, 32'h8000_0001, 32'h0000_0003,
                rv_mul(MUL_OP_MULHU, 32'h8000_0001, 32'h0000_0003), 1'b0, TIMEOUT + 3);
        run(100);
        lat = TIMEOUT + 1;
        set_req(1, MUL_OP_MUL, 32'd7, 32'd9, 32'h0, 1'b1, TIMEOUT + 2);
        run(100);

        // Multiplier never answers.
        stub = 1'b1;
        set_req(1, MUL_OP_MUL, 32'd3, 32'd5, 32'h0, 1'b1, TIMEOUT + 2);
        run(100);
        stub = 1'b0;
        lat  = 4;
        set_req(0, MUL_OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF,
                rv_mul(MUL_OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF), 1'b0, 7);
        run(100);

        // Reset while the op waits on the multiplier.
        e0 = en_count;
        set_req(0, MUL_OP_MUL, 32'd100, 32'd200, 32'd20000, 1'b0, 7);
        n = 0;
        while (en_count == e0 && n < 50) begin
            step();
            n++;
        end
        chk("t6_issued", 64'(en_count - e0), 64'd1);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        q.delete();
        pv = 2'b00; seen = 1'b0; hold_left = 0; hold_next = 0;
        tb_last = 1'b1; rsp_ready = 2'b00; req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        any_rsp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            any_rsp = any_rsp | (|rsp_valid);
        end
        chk("no_rsp_after_reset", 64'(any_rsp), 64'h0);

        // Arbitration restarts at lane0 after reset.
        set_req(1, MUL_OP_MUL,  32'hFFFF_FFFF, 32'd8, 32'hFFFF_FFF8, 1'b0, 7);
        set_req(0, MUL_OP_MULH, 32'hFFFF_FFFF, 32'd8, 32'hFFFF_FFFF, 1'b0, 7);
        run(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
